pixel_assembler: RTL
====================

PIXEL_ASSEMBLER -- requirements
Module: pixel_assembler

Interface
REQ-001 Parameter LINES, default 120, number of image lines.
REQ-002 Parameter COLUMNS, default 320, pixels per line.
REQ-003 Parameter S_DATA, default 16, pixel width in bits (RGB565).
REQ-004 Parameter S_LINE, default 7, line counter width.
REQ-005 Parameter S_COLUMN, default 9, column counter width.
REQ-006 Parameter S_ADDR, default 16, frame-memory address width.
REQ-007 Parameter TIMEOUT, default 50000, maximum clock cycles allowed between the high and low bytes of one pixel.
REQ-008 One clock; reset is synchronous and active-high; ports are named clock and reset.
REQ-009 clock  input  1  system clock, all state changes on its rising edge.
REQ-010 reset  input  1  synchronous active-high reset.
REQ-011 iniciar  input  1  single-cycle pulse, arms or re-arms frame capture.
REQ-012 dado_recebido  input  8  byte from upstream serial receiver, valid when pronto_byte=1.
REQ-013 pronto_byte  input  1  single-cycle strobe, one received byte.
REQ-014 we_pixel  output  1  frame-memory write enable, one cycle per pixel.
REQ-015 endereco  output  S_ADDR  frame-memory address = linha*COLUMNS+coluna.
REQ-016 pixel  output  S_DATA  assembled pixel {high byte, low byte}.
REQ-017 fim_recepcao  output  1  level, full frame written.
REQ-018 erro  output  1  level, byte-gap timeout occurred.
REQ-019 db_estado  output  4  current FSM state code, for 7-segment debug.

Function
REQ-020 FSM states and codes: INICIAL=0, ESPERA_ALTO=1, ESPERA_BAIXO=2, ESCREVE=3, FIM=4, ERRO=5; db_estado shall equal the code.
REQ-021 INICIAL: pronto_byte ignored; iniciar -> ESPERA_ALTO with linha=0, coluna=0, timer=0.
REQ-022 ESPERA_ALTO: pronto_byte latches dado_recebido as high byte -> ESPERA_BAIXO, timer cleared.
REQ-023 ESPERA_BAIXO: timer increments each cycle; pronto_byte latches pixel={alto,dado_recebido} -> ESCREVE.
REQ-024 ESPERA_BAIXO: timer reaching TIMEOUT-1 without pronto_byte -> ERRO.
REQ-025 ESCREVE lasts exactly one cycle: we_pixel=1, endereco and pixel stable that cycle; pixel latency = 1 cycle after low-byte strobe.
REQ-026 On leaving ESCREVE: coluna increments; at coluna=COLUMNS-1 it wraps to 0 and linha increments.
REQ-027 If the written pixel was linha=LINES-1, coluna=COLUMNS-1 -> FIM; otherwise -> ESPERA_ALTO.
REQ-028 pronto_byte coincident with ESCREVE (not last pixel) shall be latched as the next high byte and the FSM shall go to ESPERA_BAIXO; no byte is lost.
REQ-029 FIM: fim_recepcao=1; ERRO: erro=1; both held until iniciar, then -> ESPERA_ALTO with counters cleared.
REQ-030 iniciar in any state other than INICIAL restarts capture: counters, timer and latched byte cleared, -> ESPERA_ALTO, fim_recepcao and erro drop next cycle.
REQ-031 iniciar and pronto_byte in the same cycle: iniciar wins, the byte is discarded.
REQ-032 endereco shall be computed with S_ADDR-bit arithmetic; LINES*COLUMNS shall not exceed 2^S_ADDR.
REQ-033 we_pixel shall never assert outside ESCREVE.

Reset
REQ-034 reset shall override all inputs, including iniciar.
REQ-035 reset -> INICIAL; linha, coluna, timer, latched byte and pixel register = 0.
REQ-036 Outputs after reset: we_pixel=0, endereco=0, pixel=0, fim_recepcao=0, erro=0, db_estado=0.
REQ-037 reset asserted mid-frame shall abort capture with no further we_pixel pulse.

Structure
REQ-038 State codes and default dimensions (LINES, COLUMNS, widths) shall live in a shared package used by the capture interface and its controller.
REQ-039 Line/column counting with wrap and end-of-frame detection shall be one sub-module, contador_linha_coluna; the FSM and byte latch remain in the top.

Verification (LINES=2, COLUMNS=3, TIMEOUT=20)
REQ-040 reset, iniciar, bytes 0xAB,0xCD -> one we_pixel with pixel=0xABCD, endereco=0, one cycle after the 0xCD strobe.
REQ-041 12 bytes 0x00..0x0B -> six writes, addresses 0..5, pixels 0x0001,0x0203,...,0x0A0B; fim_recepcao=1 after the sixth; byte 0x0C then ignored.
REQ-042 high byte 0x11, no byte for 20 cycles -> erro=1, db_estado=5; iniciar -> erro=0, next pixel written at endereco=0.
REQ-043 high byte at address 4, then iniciar -> next two bytes 0x12,0x34 written as 0x1234 at endereco=0.
REQ-044 low byte then high byte 0x55 on the ESCREVE cycle, then 0x66 -> two consecutive writes, second pixel=0x5566 at the next address.
REQ-045 reset asserted in ESPERA_BAIXO after 3 pixels -> no we_pixel, all outputs 0, db_estado=0.

Source files
------------

// File: rtl/pixel_assembler_pkg.sv
// Shared types and default geometry for the pixel capture path.
// Byte pairs from the serial receiver become RGB565 frame-memory writes.
package pixel_assembler_pkg;

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    ESPERA_ALTO  = 4'd1,
    ESPERA_BAIXO = 4'd2,
    ESCREVE      = 4'd3,
    FIM          = 4'd4,
    ERRO         = 4'd5
  } estado_t;

  localparam int LINES_DEF    = 120;
  localparam int COLUMNS_DEF  = 320;
  localparam int S_DATA_DEF   = 16;
  localparam int S_LINE_DEF   = 7;
  localparam int S_COLUMN_DEF = 9;
  localparam int S_ADDR_DEF   = 16;
  localparam int TIMEOUT_DEF  = 50000;
  localparam int S_BYTE       = 8;

endpackage

// File: rtl/pixel_assembler_if.sv
// Capture bus: byte input from the receiver, pixel write to frame memory.
// slave is the assembler side, master is the driver/observer side.
interface pixel_assembler_if
  import pixel_assembler_pkg::*;
#(
  parameter int S_DATA = S_DATA_DEF,
  parameter int S_ADDR = S_ADDR_DEF
);
  logic              iniciar;
  logic [S_BYTE-1:0] dado_recebido;
  logic              pronto_byte;
  logic              we_pixel;
  logic [S_ADDR-1:0] endereco;
  logic [S_DATA-1:0] pixel;
  logic              fim_recepcao;
  logic              erro;
  logic [3:0]        db_estado;

  modport slave (
    input  iniciar, dado_recebido, pronto_byte,
    output we_pixel, endereco, pixel,
    output fim_recepcao, erro, db_estado
  );

  modport master (
    output iniciar, dado_recebido, pronto_byte,
    input  we_pixel, endereco, pixel,
    input  fim_recepcao, erro, db_estado
  );
endinterface

// File: rtl/pixel_assembler_contador_linha_coluna.sv
// Line/column position of the next pixel, its address and last-pixel flag.
// Wraps to the top of the frame after the last pixel.
module contador_linha_coluna
  import pixel_assembler_pkg::*;
#(
  parameter int LINES    = LINES_DEF,
  parameter int COLUMNS  = COLUMNS_DEF,
  parameter int S_LINE   = S_LINE_DEF,
  parameter int S_COLUMN = S_COLUMN_DEF,
  parameter int S_ADDR   = S_ADDR_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic              ultimo,
  output logic [S_ADDR-1:0] endereco
);
  localparam logic [S_LINE-1:0]   L_MAX = S_LINE'(LINES - 1);
  localparam logic [S_COLUMN-1:0] C_MAX = S_COLUMN'(COLUMNS - 1);

  logic [S_LINE-1:0]   linha_q, linha_d;
  logic [S_COLUMN-1:0] coluna_q, coluna_d;
  logic                fim_col;

  always_comb begin
    linha_d  = linha_q;
    coluna_d = coluna_q;
    fim_col  = (coluna_q == C_MAX);
    ultimo   = fim_col && (linha_q == L_MAX);
    if (clr) begin
      linha_d  = '0;
      coluna_d = '0;
    end else if (inc) begin
      if (fim_col) begin
        coluna_d = '0;
        linha_d  = ultimo ? '0 : linha_q + 1'b1;
      end else begin
        coluna_d = coluna_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      linha_q  <= '0;
      coluna_q <= '0;
    end else begin
      linha_q  <= linha_d;
      coluna_q <= coluna_d;
    end
  end

  assign endereco = S_ADDR'(linha_q) * S_ADDR'(COLUMNS)
                  + S_ADDR'(coluna_q);

endmodule

// File: rtl/pixel_assembler.sv
// Pairs high/low bytes into pixels and writes them in raster order,
// with a byte-gap watchdog and restartable capture.
module pixel_assembler
  import pixel_assembler_pkg::*;
#(
  parameter int LINES    = LINES_DEF,
  parameter int COLUMNS  = COLUMNS_DEF,
  parameter int S_DATA   = S_DATA_DEF,
  parameter int S_LINE   = S_LINE_DEF,
  parameter int S_COLUMN = S_COLUMN_DEF,
  parameter int S_ADDR   = S_ADDR_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  pixel_assembler_if.slave bus
);
  localparam int S_TIMER = $clog2(TIMEOUT);
  localparam logic [S_TIMER-1:0] T_MAX = S_TIMER'(TIMEOUT - 1);

  estado_t             state_q, state_d;
  logic [S_BYTE-1:0]   alto_q, alto_d;
  logic [S_DATA-1:0]   pixel_q, pixel_d;
  logic [S_TIMER-1:0]  timer_q, timer_d;
  logic                cnt_clr, cnt_inc, ultimo;

  always_comb begin
    state_d = state_q;
    alto_d  = alto_q;
    pixel_d = pixel_q;
    timer_d = timer_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (bus.iniciar) begin
      state_d = ESPERA_ALTO;
      alto_d  = '0;
      timer_d = '0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ESPERA_ALTO: if (bus.pronto_byte) begin
          alto_d  = bus.dado_recebido;
          timer_d = '0;
          state_d = ESPERA_BAIXO;
        end
        ESPERA_BAIXO: begin
          if (bus.pronto_byte) begin
            pixel_d = S_DATA'({alto_q, bus.dado_recebido});
            state_d = ESCREVE;
          end else if (timer_q == T_MAX) begin
            state_d = ERRO;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        // A byte landing on the write cycle is the next high byte.
        ESCREVE: begin
          cnt_inc = 1'b1;
          if (ultimo) begin
            state_d = FIM;
          end else if (bus.pronto_byte) begin
            alto_d  = bus.dado_recebido;
            timer_d = '0;
            state_d = ESPERA_BAIXO;
          end else begin
            state_d = ESPERA_ALTO;
          end
        end
        INICIAL, FIM, ERRO: ;
        default: state_d = INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INICIAL;
      alto_q  <= '0;
      pixel_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      alto_q  <= alto_d;
      pixel_q <= pixel_d;
      timer_q <= timer_d;
    end
  end

  contador_linha_coluna #(
    .LINES    (LINES),
    .COLUMNS  (COLUMNS),
    .S_LINE   (S_LINE),
    .S_COLUMN (S_COLUMN),
    .S_ADDR   (S_ADDR)
  ) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .ultimo   (ultimo),
    .endereco (bus.endereco)
  );

  assign bus.we_pixel     = (state_q == ESCREVE);
  assign bus.pixel        = pixel_q;
  assign bus.fim_recepcao = (state_q == FIM);
  assign bus.erro         = (state_q == ERRO);
  assign bus.db_estado    = state_q;

endmodule
